// File: rtl/biriscv_issue_sb_pkg.sv
// Shared types and constants for the biRISC-V issue scoreboard: exception width,
// issue FSM state encodings, CSR drain depth and the held-instruction record.
package biriscv_issue_sb_pkg;

   localparam int XLEN            = 32;
   localparam int EXCEPTION_W     = 6;
   localparam int CSR_DRAIN_DEPTH = 2;

   typedef enum logic [1:0] {
      ISSUE_ST_ISSUE     = 2'd0,
      ISSUE_ST_DIV_WAIT  = 2'd1,
      ISSUE_ST_CSR_DRAIN = 2'd2
   } issue_state_e;

   typedef struct packed {
      logic [XLEN-1:0]        pc;
      logic [XLEN-1:0]        opcode;
      logic                   lsu;
      logic                   csr;
      logic                   div;
      logic                   mul;
      logic                   branch;
      logic                   rd_valid;
      logic                   ra_valid;
      logic                   rb_valid;
      logic [EXCEPTION_W-1:0] exception;
   } hold_t;

   // A used, non-x0 source that names a stage whose result is not yet available.
   function automatic logic src_hazard(input logic       used,
                                       input logic [4:0] rs,
                                       input logic [4:0] rd,
                                       input logic       not_ready);
      return used & (rs != 5'd0) & (rs == rd) & not_ready;
   endfunction

endpackage

// File: rtl/biriscv_issue_bypass.sv
// Priority operand selector for one source register:
// x0, then E1 (ALU results only), then E2, then WB, then the register file.
module biriscv_issue_bypass
   import biriscv_issue_sb_pkg::*;
(
   input  logic [4:0]      rs,
   input  logic [4:0]      rd_e1,
   input  logic [4:0]      rd_e2,
   input  logic [4:0]      rd_wb,
   input  logic            alu_e1,
   input  logic [XLEN-1:0] result_e1,
   input  logic [XLEN-1:0] result_e2,
   input  logic [XLEN-1:0] result_wb,
   input  logic [XLEN-1:0] regfile,
   output logic [XLEN-1:0] value
);

   always_comb begin
      // NOTE: value gets a default before any branch so no path leaves it unassigned (no latch).
      value = regfile;
      if (rs == 5'd0) begin
         value = '0;
      end else if (alu_e1 && (rs == rd_e1)) begin
         value = result_e1;
      end else if (rs == rd_e2) begin
         value = result_e2;
      end else if (rs == rd_wb) begin
         value = result_wb;
      end
   end

endmodule

// File: rtl/biriscv_issue_sb.sv
// Issue scoreboard: one-entry hold, RAW hazard detection, operand bypass, DIV/CSR
// serialisation. Define BIRISCV_LOAD_MUL_BYPASS_EN to forward load/mul results from E2.
module biriscv_issue_sb
   import biriscv_issue_sb_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,

   input  logic                   fetch_valid_i,
   output logic                   fetch_accept_o,
   input  logic [31:0]            fetch_pc_i,
   input  logic [31:0]            fetch_opcode_i,
   input  logic                   fetch_lsu_i,
   input  logic                   fetch_csr_i,
   input  logic                   fetch_div_i,
   input  logic                   fetch_mul_i,
   input  logic                   fetch_branch_i,
   input  logic                   fetch_rd_valid_i,
   input  logic                   fetch_ra_valid_i,
   input  logic                   fetch_rb_valid_i,
   input  logic [EXCEPTION_W-1:0] fetch_exception_i,

   input  logic                   intr_pending_i,
   input  logic [31:0]            ra_value_i,
   input  logic [31:0]            rb_value_i,

   output logic                   issue_valid_o,
   output logic                   issue_accept_o,
   output logic                   issue_stall_o,
   output logic                   issue_lsu_o,
   output logic                   issue_csr_o,
   output logic                   issue_div_o,
   output logic                   issue_mul_o,
   output logic                   issue_branch_o,
   output logic                   issue_rd_valid_o,
   output logic [4:0]             issue_rd_o,
   output logic [EXCEPTION_W-1:0] issue_exception_o,
   output logic                   take_interrupt_o,
   output logic [31:0]            issue_pc_o,
   output logic [31:0]            issue_opcode_o,
   output logic [31:0]            issue_operand_ra_o,
   output logic [31:0]            issue_operand_rb_o,

   input  logic [4:0]             rd_e1_i,
   input  logic [4:0]             rd_e2_i,
   input  logic [4:0]             rd_wb_i,
   input  logic                   load_e1_i,
   input  logic                   mul_e1_i,
   input  logic                   load_e2_i,
   input  logic                   mul_e2_i,
   input  logic [31:0]            alu_result_e1_i,
   input  logic [31:0]            result_e2_i,
   input  logic [31:0]            result_wb_i,

   input  logic                   stall_i,
   input  logic                   div_complete_i,
   input  logic                   squash_e1_e2_i,
   input  logic                   squash_wb_i
);

   hold_t        hold_q;
   logic         hold_valid_q;
   issue_state_e state_q, state_d;
   logic [1:0]   csr_cnt_q, csr_cnt_d;

   logic [4:0]   rs1, rs2;
   logic         e1_slow, e2_slow, e1_alu;
   logic         hazard, issue_fire, capture, squash;
   logic [31:0]  ra_fwd, rb_fwd;

   assign rs1     = hold_q.opcode[19:15];
   assign rs2     = hold_q.opcode[24:20];
   assign squash  = squash_e1_e2_i | squash_wb_i;
   assign e1_slow = load_e1_i | mul_e1_i;
   assign e1_alu  = ~e1_slow;

`ifdef BIRISCV_LOAD_MUL_BYPASS_EN
   assign e2_slow = 1'b0;
`else
   assign e2_slow = load_e2_i | mul_e2_i;
`endif

   assign hazard = hold_valid_q &
                   (src_hazard(hold_q.ra_valid, rs1, rd_e1_i, e1_slow) |
                    src_hazard(hold_q.ra_valid, rs1, rd_e2_i, e2_slow) |
                    src_hazard(hold_q.rb_valid, rs2, rd_e1_i, e1_slow) |
                    src_hazard(hold_q.rb_valid, rs2, rd_e2_i, e2_slow));

   assign issue_valid_o    = hold_valid_q;
   assign issue_accept_o   = hold_valid_q & ~stall_i & ~hazard & (state_q == ISSUE_ST_ISSUE);
   assign issue_fire       = issue_valid_o & issue_accept_o;
   assign issue_stall_o    = stall_i | (hold_valid_q & ~issue_accept_o);
   assign take_interrupt_o = intr_pending_i & issue_accept_o;
   assign fetch_accept_o   = ~rst_i & (~hold_valid_q | issue_fire);
   assign capture          = fetch_valid_i & fetch_accept_o;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i || squash) begin
         hold_valid_q <= 1'b0;
      end else if (capture) begin
         hold_valid_q <= 1'b1;
      end else if (issue_fire) begin
         hold_valid_q <= 1'b0;
      end
   end

   // NOTE: the payload is deliberately not reset; every consumer is qualified by hold_valid_q.
   always_ff @(posedge clk_i) begin
      if (capture) begin
         hold_q.pc        <= fetch_pc_i;
         hold_q.opcode    <= fetch_opcode_i;
         hold_q.lsu       <= fetch_lsu_i;
         hold_q.csr       <= fetch_csr_i;
         hold_q.div       <= fetch_div_i;
         hold_q.mul       <= fetch_mul_i;
         hold_q.branch    <= fetch_branch_i;
         hold_q.rd_valid  <= fetch_rd_valid_i;
         hold_q.ra_valid  <= fetch_ra_valid_i;
         hold_q.rb_valid  <= fetch_rb_valid_i;
         hold_q.exception <= fetch_exception_i;
      end
   end

   always_comb begin
      state_d   = state_q;
      csr_cnt_d = csr_cnt_q;
      if (squash) begin
         state_d   = ISSUE_ST_ISSUE;
         csr_cnt_d = 2'd0;
      end else begin
         case (state_q)
            ISSUE_ST_ISSUE: begin
               if (issue_fire && hold_q.div) begin
                  state_d = ISSUE_ST_DIV_WAIT;
               end else if (issue_fire && hold_q.csr) begin
                  state_d   = ISSUE_ST_CSR_DRAIN;
                  csr_cnt_d = 2'(CSR_DRAIN_DEPTH);
               end
            end
            ISSUE_ST_DIV_WAIT: begin
               if (div_complete_i) state_d = ISSUE_ST_ISSUE;
            end
            ISSUE_ST_CSR_DRAIN: begin
               // Leaving on the decrement that reaches zero gives exactly CSR_DRAIN_DEPTH blocked cycles.
               if (!stall_i) begin
                  if (csr_cnt_q <= 2'd1) begin
                     csr_cnt_d = 2'd0;
                     state_d   = ISSUE_ST_ISSUE;
                  end else begin
                     csr_cnt_d = csr_cnt_q - 2'd1;
                  end
               end
            end
            default: begin
               state_d   = ISSUE_ST_ISSUE;
               csr_cnt_d = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ISSUE_ST_ISSUE;
         csr_cnt_q <= 2'd0;
      end else begin
         state_q   <= state_d;
         csr_cnt_q <= csr_cnt_d;
      end
   end

   biriscv_issue_bypass u_bypass_ra (
      .rs        (rs1),
      .rd_e1     (rd_e1_i),
      .rd_e2     (rd_e2_i),
      .rd_wb     (rd_wb_i),
      .alu_e1    (e1_alu),
      .result_e1 (alu_result_e1_i),
      .result_e2 (result_e2_i),
      .result_wb (result_wb_i),
      .regfile   (ra_value_i),
      .value     (ra_fwd)
   );

   biriscv_issue_bypass u_bypass_rb (
      .rs        (rs2),
      .rd_e1     (rd_e1_i),
      .rd_e2     (rd_e2_i),
      .rd_wb     (rd_wb_i),
      .alu_e1    (e1_alu),
      .result_e1 (alu_result_e1_i),
      .result_e2 (result_e2_i),
      .result_wb (result_wb_i),
      .regfile   (rb_value_i),
      .value     (rb_fwd)
   );

   assign issue_pc_o         = hold_valid_q ? hold_q.pc        : '0;
   assign issue_opcode_o     = hold_valid_q ? hold_q.opcode    : '0;
   assign issue_operand_ra_o = hold_valid_q ? ra_fwd           : '0;
   assign issue_operand_rb_o = hold_valid_q ? rb_fwd           : '0;
   assign issue_exception_o  = hold_valid_q ? hold_q.exception : '0;
   assign issue_rd_o         = (hold_valid_q && hold_q.rd_valid) ? hold_q.opcode[11:7] : 5'd0;
   assign issue_lsu_o        = hold_valid_q & hold_q.lsu;
   assign issue_csr_o        = hold_valid_q & hold_q.csr;
   assign issue_div_o        = hold_valid_q & hold_q.div;
   assign issue_mul_o        = hold_valid_q & hold_q.mul;
   assign issue_branch_o     = hold_valid_q & hold_q.branch;
   assign issue_rd_valid_o   = hold_valid_q & hold_q.rd_valid;

endmodule

// File: tb/tb_biriscv_issue_sb.sv
// Self-checking bench for biriscv_issue_sb: directed scenarios plus randomized traffic
// compared every cycle against a behavioural issue model.
module tb_biriscv_issue_sb;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   logic        fetch_valid_i, fetch_accept_o;
   logic [31:0] fetch_pc_i, fetch_opcode_i;
   logic        fetch_lsu_i, fetch_csr_i, fetch_div_i, fetch_mul_i, fetch_branch_i;
   logic        fetch_rd_valid_i, fetch_ra_valid_i, fetch_rb_valid_i;
   logic [5:0]  fetch_exception_i;
   logic        intr_pending_i;
   logic [31:0] ra_value_i, rb_value_i;
   logic        issue_valid_o, issue_accept_o, issue_stall_o;
   logic        issue_lsu_o, issue_csr_o, issue_div_o, issue_mul_o, issue_branch_o, issue_rd_valid_o;
   logic [4:0]  issue_rd_o;
   logic [5:0]  issue_exception_o;
   logic        take_interrupt_o;
   logic [31:0] issue_pc_o, issue_opcode_o, issue_operand_ra_o, issue_operand_rb_o;
   logic [4:0]  rd_e1_i, rd_e2_i, rd_wb_i;
   logic        load_e1_i, mul_e1_i, load_e2_i, mul_e2_i;
   logic [31:0] alu_result_e1_i, result_e2_i, result_wb_i;
   logic        stall_i, div_complete_i, squash_e1_e2_i, squash_wb_i;

   biriscv_issue_sb dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .fetch_valid_i(fetch_valid_i), .fetch_accept_o(fetch_accept_o),
      .fetch_pc_i(fetch_pc_i), .fetch_opcode_i(fetch_opcode_i),
      .fetch_lsu_i(fetch_lsu_i), .fetch_csr_i(fetch_csr_i), .fetch_div_i(fetch_div_i),
      .fetch_mul_i(fetch_mul_i), .fetch_branch_i(fetch_branch_i),
      .fetch_rd_valid_i(fetch_rd_valid_i), .fetch_ra_valid_i(fetch_ra_valid_i),
      .fetch_rb_valid_i(fetch_rb_valid_i), .fetch_exception_i(fetch_exception_i),
      .intr_pending_i(intr_pending_i), .ra_value_i(ra_value_i), .rb_value_i(rb_value_i),
      .issue_valid_o(issue_valid_o), .issue_accept_o(issue_accept_o), .issue_stall_o(issue_stall_o),
      .issue_lsu_o(issue_lsu_o), .issue_csr_o(issue_csr_o), .issue_div_o(issue_div_o),
      .issue_mul_o(issue_mul_o), .issue_branch_o(issue_branch_o), .issue_rd_valid_o(issue_rd_valid_o),
      .issue_rd_o(issue_rd_o), .issue_exception_o(issue_exception_o),
      .take_interrupt_o(take_interrupt_o),
      .issue_pc_o(issue_pc_o), .issue_opcode_o(issue_opcode_o),
      .issue_operand_ra_o(issue_operand_ra_o), .issue_operand_rb_o(issue_operand_rb_o),
      .rd_e1_i(rd_e1_i), .rd_e2_i(rd_e2_i), .rd_wb_i(rd_wb_i),
      .load_e1_i(load_e1_i), .mul_e1_i(mul_e1_i), .load_e2_i(load_e2_i), .mul_e2_i(mul_e2_i),
      .alu_result_e1_i(alu_result_e1_i), .result_e2_i(result_e2_i), .result_wb_i(result_wb_i),
      .stall_i(stall_i), .div_complete_i(div_complete_i),
      .squash_e1_e2_i(squash_e1_e2_i), .squash_wb_i(squash_wb_i)
   );

`ifdef BIRISCV_LOAD_MUL_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   localparam int C_ALU = 0, C_LSU = 1, C_CSR = 2, C_DIV = 3, C_MUL = 4, C_BR = 5;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] op;
      logic [5:0]  exc;
      logic lsu, csr, div, mul, br, rdv, rav, rbv;
   } ins_t;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
      end
   endtask

   // Behavioural model: a one-slot buffer plus "what blocks issue right now".
   bit   m_hv;
   ins_t m_ins;
   bit   m_div_busy;
   int   m_csr_left;

   bit          e_accept, e_fetch_accept, e_stall, e_intr;
   logic [31:0] e_ra, e_rb;
   logic [31:0] obs_acc, obs_valid, obs_facc, obs_ra, obs_rb, obs_intr;

   function automatic bit not_ready(input logic used, input logic [4:0] rs);
      if (!used || rs == 5'd0) return 1'b0;
      if (rs == rd_e1_i && (load_e1_i || mul_e1_i)) return 1'b1;
      if (!BYPASS && rs == rd_e2_i && (load_e2_i || mul_e2_i)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] rf);
      if (rs == 5'd0) return 32'd0;
      if (rs == rd_e1_i && !(load_e1_i || mul_e1_i)) return alu_result_e1_i;
      if (rs == rd_e2_i) return result_e2_i;
      if (rs == rd_wb_i) return result_wb_i;
      return rf;
   endfunction

   function automatic logic [31:0] mk_op(input int rd, input int rs1, input int rs2);
      logic [4:0] d, a, b;
      d = 5'(rd); a = 5'(rs1); b = 5'(rs2);
      return {7'd0, b, a, 3'd0, d, 7'h33};
   endfunction

   function automatic ins_t mk_ins(input int cls, input int rd, input int rs1, input int rs2);
      ins_t i;
      i.pc  = $urandom & 32'hFFFF_FFFC;
      i.op  = mk_op(rd, rs1, rs2);
      i.exc = 6'd0;
      i.lsu = (cls == C_LSU);
      i.csr = (cls == C_CSR);
      i.div = (cls == C_DIV);
      i.mul = (cls == C_MUL);
      i.br  = (cls == C_BR);
      i.rdv = (cls != C_BR);
      i.rav = 1'b1;
      i.rbv = (cls == C_LSU) ? 1'($urandom_range(0, 1)) : 1'b1;
      return i;
   endfunction

   task automatic drive_fetch(input ins_t i, input logic v);
      fetch_valid_i     = v;
      fetch_pc_i        = i.pc;
      fetch_opcode_i    = i.op;
      fetch_exception_i = i.exc;
      fetch_lsu_i       = i.lsu;
      fetch_csr_i       = i.csr;
      fetch_div_i       = i.div;
      fetch_mul_i       = i.mul;
      fetch_branch_i    = i.br;
      fetch_rd_valid_i  = i.rdv;
      fetch_ra_valid_i  = i.rav;
      fetch_rb_valid_i  = i.rbv;
   endtask

   task automatic idle_inputs();
      drive_fetch(mk_ins(C_ALU, 0, 0, 0), 1'b0);
      intr_pending_i = 0; stall_i = 0; div_complete_i = 0;
      squash_e1_e2_i = 0; squash_wb_i = 0;
      rd_e1_i = 0; rd_e2_i = 0; rd_wb_i = 0;
      load_e1_i = 0; mul_e1_i = 0; load_e2_i = 0; mul_e2_i = 0;
      alu_result_e1_i = $urandom; result_e2_i = $urandom; result_wb_i = $urandom;
      ra_value_i = $urandom; rb_value_i = $urandom;
   endtask

   task automatic model_eval();
      logic [4:0] rs1, rs2;
      bit blocked;
      rs1 = m_ins.op[19:15];
      rs2 = m_ins.op[24:20];
      blocked        = m_div_busy || (m_csr_left > 0) ||
                       not_ready(m_ins.rav, rs1) || not_ready(m_ins.rbv, rs2);
      e_accept       = m_hv && !stall_i && !blocked;
      e_fetch_accept = !rst_i && (!m_hv || e_accept);
      e_stall        = stall_i || (m_hv && !e_accept);
      e_intr         = intr_pending_i && e_accept;
      e_ra           = m_hv ? operand(rs1, ra_value_i) : 32'd0;
      e_rb           = m_hv ? operand(rs2, rb_value_i) : 32'd0;
   endtask

   task automatic compare_all();
      check("fetch_accept", fetch_accept_o, e_fetch_accept);
      check("issue_valid", issue_valid_o, m_hv);
      check("issue_accept", issue_accept_o, e_accept);
      check("issue_stall", issue_stall_o, e_stall);
      check("take_interrupt", take_interrupt_o, e_intr);
      check("operand_ra", issue_operand_ra_o, e_ra);
      check("operand_rb", issue_operand_rb_o, e_rb);
      check("issue_pc", issue_pc_o, m_hv ? m_ins.pc : 32'd0);
      check("issue_opcode", issue_opcode_o, m_hv ? m_ins.op : 32'd0);
      check("issue_rd", issue_rd_o, (m_hv && m_ins.rdv) ? m_ins.op[11:7] : 5'd0);
      check("issue_exception", issue_exception_o, m_hv ? m_ins.exc : 6'd0);
      check("issue_flags",
            {issue_lsu_o, issue_csr_o, issue_div_o, issue_mul_o, issue_branch_o, issue_rd_valid_o},
            m_hv ? {m_ins.lsu, m_ins.csr, m_ins.div, m_ins.mul, m_ins.br, m_ins.rdv} : 6'd0);
   endtask

   task automatic model_step();
      ins_t f;
      if (rst_i || squash_e1_e2_i || squash_wb_i) begin
         m_hv = 0; m_div_busy = 0; m_csr_left = 0;
         return;
      end
      if (m_div_busy && div_complete_i) m_div_busy = 0;
      if (m_csr_left > 0 && !stall_i) m_csr_left--;
      if (e_accept && m_ins.div) m_div_busy = 1;
      if (e_accept && m_ins.csr) m_csr_left = 2;
      if (fetch_valid_i && e_fetch_accept) begin
         f.pc = fetch_pc_i; f.op = fetch_opcode_i; f.exc = fetch_exception_i;
         f.lsu = fetch_lsu_i; f.csr = fetch_csr_i; f.div = fetch_div_i; f.mul = fetch_mul_i;
         f.br = fetch_branch_i; f.rdv = fetch_rd_valid_i; f.rav = fetch_ra_valid_i;
         f.rbv = fetch_rb_valid_i;
         m_ins = f;
         m_hv  = 1;
      end else if (e_accept) begin
         m_hv = 0;
      end
   endtask

   // One clock: inputs are already driven; check mid-cycle, advance model, cross the edge.
   task automatic cycle();
      #1;
      model_eval();
      compare_all();
      obs_acc = issue_accept_o; obs_valid = issue_valid_o; obs_facc = fetch_accept_o;
      obs_ra = issue_operand_ra_o; obs_rb = issue_operand_rb_o; obs_intr = take_interrupt_o;
      model_step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int got_k, waits, accepts;
      logic [31:0] exp_ra;

      idle_inputs();
      rst_i = 1'b1;
      m_hv = 0; m_div_busy = 0; m_csr_left = 0; m_ins = '0;
      @(posedge clk_i); #1;

      // Reset behaviour
      cycle();
      check("rst_fetch_accept", obs_facc, 0);
      rst_i = 1'b0;
      cycle();
      check("post_rst_fetch_accept", obs_facc, 1);
      check("post_rst_valid", obs_valid, 0);

      // Back-to-back independent ADDs
      for (int i = 0; i < 6; i++) begin
         drive_fetch(mk_ins(C_ALU, 10 + i, 1 + i, 2), 1'b1);
         ra_value_i = $urandom;
         exp_ra = ra_value_i;
         cycle();
         if (i > 0) begin
            check("b2b_accept", obs_acc, 1);
            check("b2b_ra", obs_ra, exp_ra);
         end
      end
      fetch_valid_i = 0;
      cycle();

      // Load-use: LW x5, then ADD x6,x1,x5
      idle_inputs();
      drive_fetch(mk_ins(C_LSU, 5, 2, 0), 1'b1);
      cycle();
      drive_fetch(mk_ins(C_ALU, 6, 1, 5), 1'b1);
      cycle();
      check("lw_fire", obs_acc, 1);
      fetch_valid_i = 0;
      got_k = 99;
      for (int k = 0; k < 4; k++) begin
         rd_e1_i = 0; load_e1_i = 0; rd_e2_i = 0; load_e2_i = 0; rd_wb_i = 0;
         if (k == 0) begin rd_e1_i = 5; load_e1_i = 1; end
         if (k == 1) begin rd_e2_i = 5; load_e2_i = 1; result_e2_i = BYPASS ? 32'h1234 : 32'hBAD0; end
         if (k == 2) begin rd_wb_i = 5; result_wb_i = 32'h1234; end
         cycle();
         if (obs_acc[0]) begin
            got_k = k;
            check("load_use_rb", obs_rb, 32'h1234);
            break;
         end
      end
      check("load_use_bubbles", got_k, BYPASS ? 1 : 2);

      // Forwarding priority: E1 ALU beats WB; x0 is always zero
      idle_inputs();
      drive_fetch(mk_ins(C_ALU, 8, 7, 0), 1'b1);
      cycle();
      fetch_valid_i = 0;
      rd_e1_i = 7; alu_result_e1_i = 32'hA5; rd_wb_i = 7; result_wb_i = 32'h11;
      ra_value_i = 32'h55; rb_value_i = 32'h66;
      cycle();
      check("fwd_e1_over_wb", obs_ra, 32'hA5);
      check("fwd_x0", obs_rb, 32'h0);
      check("fwd_accept", obs_acc, 1);

      // Stray div_complete while idle is ignored
      idle_inputs();
      div_complete_i = 1;
      cycle();
      div_complete_i = 0;

      // Divide blocks until the cycle after div_complete
      drive_fetch(mk_ins(C_DIV, 9, 1, 2), 1'b1);
      cycle();
      drive_fetch(mk_ins(C_ALU, 11, 3, 4), 1'b1);
      cycle();
      check("div_fire", obs_acc, 1);
      fetch_valid_i = 0;
      accepts = 0;
      for (int i = 0; i < 33; i++) begin
         cycle();
         if (obs_acc[0]) accepts++;
      end
      check("div_no_issue", accepts, 0);
      div_complete_i = 1;
      cycle();
      check("div_complete_cycle", obs_acc, 0);
      div_complete_i = 0;
      cycle();
      check("div_next_issue", obs_acc, 1);

      // CSR drain delays the next instruction by 2 cycles
      idle_inputs();
      drive_fetch(mk_ins(C_CSR, 12, 1, 0), 1'b1);
      cycle();
      drive_fetch(mk_ins(C_ALU, 13, 1, 2), 1'b1);
      cycle();
      check("csr_fire", obs_acc, 1);
      fetch_valid_i = 0;
      waits = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (obs_acc[0]) break;
         waits++;
      end
      check("csr_delay", waits, 2);

      // Squash during a stalled drain returns to ISSUE and empties the hold
      idle_inputs();
      drive_fetch(mk_ins(C_CSR, 12, 1, 0), 1'b1);
      cycle();
      drive_fetch(mk_ins(C_ALU, 13, 1, 2), 1'b1);
      cycle();
      fetch_valid_i = 0; stall_i = 1; squash_wb_i = 1;
      cycle();
      squash_wb_i = 0;
      drive_fetch(mk_ins(C_ALU, 14, 1, 2), 1'b1);
      cycle();
      check("squash_hold_cleared", obs_valid, 0);
      check("squash_fetch_accept", obs_facc, 1);
      stall_i = 0; fetch_valid_i = 0;
      cycle();
      check("squash_state_issue", obs_acc, 1);

      // Interrupt tagging
      idle_inputs();
      drive_fetch(mk_ins(C_ALU, 15, 3, 2), 1'b1);
      cycle();
      fetch_valid_i = 0; intr_pending_i = 1;
      cycle();
      check("intr_take", obs_intr, 1);
      intr_pending_i = 0;
      drive_fetch(mk_ins(C_ALU, 16, 4, 2), 1'b1);
      cycle();
      fetch_valid_i = 0; intr_pending_i = 1; rd_e1_i = 4; load_e1_i = 1;
      cycle();
      check("intr_hazard_blocked", obs_intr, 0);
      check("intr_hazard_accept", obs_acc, 0);
      rd_e1_i = 0; load_e1_i = 0;
      cycle();
      check("intr_after_hazard", obs_intr, 1);

      // Reset mid-divide abandons the wait
      idle_inputs();
      drive_fetch(mk_ins(C_DIV, 9, 1, 2), 1'b1);
      cycle();
      fetch_valid_i = 0;
      cycle();
      cycle(); cycle(); cycle();
      rst_i = 1;
      cycle();
      rst_i = 0;
      drive_fetch(mk_ins(C_ALU, 17, 1, 2), 1'b1);
      cycle();
      check("rst_div_capture", obs_facc, 1);
      fetch_valid_i = 0;
      cycle();
      check("rst_div_issue", obs_acc, 1);

      // Randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         int   r;
         int   cls;
         ins_t ri;
         r = $urandom_range(0, 15);
         cls = (r == 0) ? C_DIV : (r == 1) ? C_CSR : (r < 5) ? C_LSU :
               (r < 7) ? C_MUL : (r == 7) ? C_BR : C_ALU;
         ri = mk_ins(cls, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) ri.exc = 6'($urandom_range(1, 63));
         drive_fetch(ri, 1'($urandom_range(0, 9) < 7));
         rd_e1_i = 5'($urandom_range(0, 7));
         rd_e2_i = 5'($urandom_range(0, 7));
         rd_wb_i = 5'($urandom_range(0, 7));
         load_e1_i = 1'($urandom_range(0, 3) == 0);
         mul_e1_i  = 1'($urandom_range(0, 5) == 0);
         load_e2_i = 1'($urandom_range(0, 3) == 0);
         mul_e2_i  = 1'($urandom_range(0, 5) == 0);
         alu_result_e1_i = $urandom; result_e2_i = $urandom; result_wb_i = $urandom;
         ra_value_i = $urandom; rb_value_i = $urandom;
         stall_i        = 1'($urandom_range(0, 4) == 0);
         div_complete_i = 1'($urandom_range(0, 6) == 0);
         squash_e1_e2_i = 1'($urandom_range(0, 39) == 0);
         squash_wb_i    = 1'($urandom_range(0, 39) == 0);
         intr_pending_i = 1'($urandom_range(0, 2) == 0);
         rst_i          = 1'($urandom_range(0, 99) == 0);
         cycle();
      end
      rst_i = 0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
